// File: rtl/fetch_exec_latch.sv
// fetch_exec_latch: owns the fetch PC and the F->E pipeline register.
// Applies stalls, control squashes and taken-branch redirects from the
// hazard unit and execute stage. Keeps saturating stall/flush event counters.
module fetch_exec_latch #(
    parameter int                PC_W        = 32,
    parameter int                INSTR_W     = 32,
    parameter logic [PC_W-1:0]   RESET_PC    = '0,
    parameter int                FLUSH_SLOTS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallF,
    input  logic               stallC,
    input  logic               isBranchTakenE,
    input  logic [PC_W-1:0]    branchTargetE,
    input  logic [INSTR_W-1:0] instrF,
    output logic [PC_W-1:0]    pcF,
    output logic [INSTR_W-1:0] instrE,
    output logic [PC_W-1:0]    pcE,
    output logic               validE,
    output logic [15:0]        stallCount,
    output logic [15:0]        flushCount
);

    typedef enum logic {RUN, FLUSH} state_e;

    // Bubbles still owed after the redirect cycle itself supplies the first.
    localparam logic [1:0] SLOTS_M1 = 2'(FLUSH_SLOTS - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // F->E pipeline register contents
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               valid;
    } fe_reg_t;

    state_e             state_q, state_d;
    logic [1:0]         slot_q, slot_d;
    logic [PC_W-1:0]    pc_f_q, pc_f_d;
    fe_reg_t            fe_q, fe_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic [15:0]        flush_cnt_q, flush_cnt_d;
    logic               redirect;

    // A taken branch only counts when a real instruction sits in execute;
    // in FLUSH validE is always 0 so this naturally ignores bubbles there.
    assign redirect = (state_q == RUN) && isBranchTakenE && fe_q.valid;

    // State register and all datapath flops; synchronous reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            slot_q      <= 2'd0;
            pc_f_q      <= RESET_PC;
            fe_q        <= '0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            pc_f_q      <= pc_f_d;
            fe_q        <= fe_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic: enter FLUSH on redirect when more than one bubble
    // is needed, count down, return to RUN on the 1 -> 0 transition.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            RUN: begin
                if (redirect && (FLUSH_SLOTS > 1)) begin
                    state_d = FLUSH;
                    slot_d  = SLOTS_M1;
                end
            end
            FLUSH: begin
                slot_d = slot_q - 2'd1;
                if (slot_q <= 2'd1) begin
                    state_d = RUN;
                    slot_d  = 2'd0;
                end
            end
            default: begin
                state_d = RUN;
                slot_d  = 2'd0;
            end
        endcase
    end

    // Datapath/output logic: default is hold PC and inject a bubble.
    always_comb begin
        pc_f_d      = pc_f_q;
        fe_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == RUN) begin
            if (redirect) begin
                pc_f_d = branchTargetE;
                if (flush_cnt_q != CNT_MAX)
                    flush_cnt_d = flush_cnt_q + 16'd1;
            end else if (stallC) begin
                // squash only; stallF alongside it is not counted
            end else if (stallF) begin
                if (stall_cnt_q != CNT_MAX)
                    stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                fe_d.instr = instrF;
                fe_d.pc    = pc_f_q;
                fe_d.valid = 1'b1;
                pc_f_d     = pc_f_q + PC_W'(4);
            end
        end
        // FLUSH: stalls are ignored, PC holds at the target, bubble out.
    end

    assign pcF        = pc_f_q;
    assign instrE     = fe_q.instr;
    assign pcE        = fe_q.pc;
    assign validE     = fe_q.valid;
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule

// File: doc/fetch_exec_latch.md
# fetch_exec_latch

Fetch-side consumer of the hazard unit's control outputs in the 2-stage pipeline. Owns the fetch PC and the F→E pipeline register. It applies fetch stalls, control squashes and taken-branch redirects issued by the hazard logic and the execute stage, inserting bubbles into execute where required. It also keeps saturating stall and flush event counters for performance debug.

## Interface

Parameters:
- PC_W, 32, width of the program counter
- INSTR_W, 32, instruction width
- RESET_PC, 0, fetch address loaded on reset
- FLUSH_SLOTS, 1, bubbles injected after a taken-branch redirect; legal range 1..3

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- stallF  in  1  fetch stall request (RAW hazard): hold PC, bubble into execute
- stallC  in  1  control squash request: hold PC, bubble into execute
- isBranchTakenE  in  1  execute-stage branch resolved taken
- branchTargetE  in  PC_W  redirect address, valid with isBranchTakenE
- instrF  in  INSTR_W  instruction-memory data for the current pcF
- pcF  out  PC_W  current fetch address
- instrE  out  INSTR_W  instruction in execute; 0 is the NOP encoding
- pcE  out  PC_W  PC of the instruction in execute
- validE  out  1  instrE is a real instruction; 0 means bubble
- stallCount  out  16  saturating count of honoured stallF cycles
- flushCount  out  16  saturating count of honoured redirects

## Operation

- Reset (synchronous, highest priority) sets pcF=RESET_PC, pcE=0, instrE=0, validE=0, state=RUN, flush counter=0, stallCount=0, flushCount=0. Reset asserted mid-FLUSH abandons the flush.
- FSM states are RUN and FLUSH. A 2-bit down-counter tracks the remaining flush bubbles.
- isBranchTakenE is honoured only when validE=1. It is ignored on bubbles.
- Priority within RUN is reset > redirect > stallC > stallF > advance.
  - Redirect: pcF<=branchTargetE; instrE<=0; validE<=0; pcE<=0; flushCount++. If FLUSH_SLOTS>1, go to FLUSH with counter=FLUSH_SLOTS-1. Otherwise stay in RUN.
  - stallC: pcF holds; instrE<=0; validE<=0; pcE<=0. No counter changes.
  - stallF: pcF holds; instrE<=0; validE<=0; pcE<=0; stallCount++.
  - Advance: instrE<=instrF; pcE<=pcF; validE<=1; pcF<=pcF+4.
- In FLUSH:
  - Each cycle: pcF holds at the target; instrE<=0; validE<=0; counter decrements.
  - When the counter reaches 0 (transition from 1), the next state is RUN.
  - stallF and stallC are ignored in FLUSH and are not counted.
- Arithmetic and counters:
  - pcF+4 wraps modulo 2^PC_W.
  - stallCount and flushCount saturate at 16'hFFFF and never wrap.
- If stallF and stallC are both asserted, stallC wins and stallCount is not incremented.

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- Latency from instrF to instrE is 1 cycle.
- Redirect: the first fetch at branchTargetE appears on pcF in the cycle after the edge where isBranchTakenE=1 and validE=1 are sampled. That target instruction enters execute FLUSH_SLOTS cycles after the redirect edge.
- Each stall cycle inserts exactly 1 bubble. There is no skid; the hazard unit must re-present the request every cycle it wants to hold.
- Back-to-back stallF for N cycles gives N bubbles, with pcF constant throughout, and stallCount increases by N.

## Test plan

- Reset then free-run with RESET_PC=0x100, instrF=pcF-derived pattern -> pcF steps 0x100, 0x104, 0x108. instrE and pcE lag pcF by 1 cycle. validE is 0 for the first cycle only.
- stallF=1 for 3 cycles while pcF=0x108 -> pcF stays at 0x108, validE=0 for 3 cycles, stallCount=3. Execution then resumes with pcE=0x108.
- Taken branch with FLUSH_SLOTS=3 and target 0x200, in execute with validE=1 -> pcF=0x200 next cycle, 3 consecutive bubbles, flushCount=1, and pcE=0x200 with validE=1 on the following cycle. A stallF pulse during FLUSH leaves stallCount unchanged.
- isBranchTakenE=1 while validE=0, and stallF and stallC asserted together -> no redirect occurs. The stall is handled as stallC: a bubble is inserted, pcF holds, and stallCount is unchanged.
- pcF=0xFFFF_FFFC with an advance -> pcF=0x0000_0000. With stallCount preloaded to 0xFFFF via a long stall run, a further stallF leaves it at 0xFFFF.
- Reset asserted in the 2nd FLUSH cycle -> on the next cycle pcF=RESET_PC, state=RUN, validE=0, and both counters are 0.
